nibble_add_ctrl: RTL and testbench

NIBBLE_ADD_CTRL -- requirements
Module: nibble_add_ctrl

---
 rtl/nibble_add_ctrl_if.sv | 32 +++
 rtl/nibble_add_ctrl.sv | 117 +++++++++++
 tb/tb_nibble_add_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_add_ctrl_if.sv
// Bundles the two requester channels and the shared result/status bus of the
// nibble-serial adder; master drives requests, slave is the adder itself.
interface nibble_add_ctrl_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         req0;
    logic         req1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         cin0;
    logic         cin1;
    logic [1:0]   gnt;
    logic         busy;
    logic [W-1:0] sum;
    logic         cout;
    logic         done;
    logic         done_id;

    modport master (
        output req0, req1, a0, b0, a1, b1, cin0, cin1,
        input  gnt, busy, sum, cout, done, done_id
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1, cin0, cin1,
        output gnt, busy, sum, cout, done, done_id
    );
endinterface

// File: rtl/nibble_add_ctrl.sv
// Two-requester round-robin front end for a W-bit adder built from a single
// 4-bit slice that is stepped across the operands one nibble per clock.
module nibble_add_ctrl #(
    parameter int NIB = 4
) (
    input  logic              clk,
    input  logic              rst,
    nibble_add_ctrl_if.slave  bus
);
    localparam int W  = 4 * NIB;
    localparam int CW = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t         r_state;
    logic [W-1:0]   r_opA;
    logic [W-1:0]   r_opB;
    logic [W-1:0]   r_result;
    logic [W-1:0]   r_sum;
    logic [CW-1:0]  r_count;
    logic           r_carry;
    logic           r_cout;
    logic           r_done;
    logic           r_doneId;
    logic           r_curId;
    logic           r_lastId;
    logic [1:0]     r_gnt;

    logic [3:0]     w_sliceX;
    logic [3:0]     w_sliceY;
    logic [4:0]     w_slice;
    logic [W-1:0]   w_resultNext;
    logic           w_anyReq;
    logic           w_winner;
    logic           w_lastNibble;

    // The one and only adder: nibble k of each operand plus the running carry.
    always_comb begin
        w_sliceX = r_opA[4*r_count +: 4];
        w_sliceY = r_opB[4*r_count +: 4];
        w_slice  = {1'b0, w_sliceX} + {1'b0, w_sliceY} + {4'b0000, r_carry};
    end

    always_comb begin
        w_resultNext                   = r_result;
        w_resultNext[4*r_count +: 4]   = w_slice[3:0];
    end

    // A tie goes to whichever requester did not win last time.
    always_comb begin
        w_anyReq     = bus.req0 | bus.req1;
        w_winner     = (bus.req0 & bus.req1) ? ~r_lastId : bus.req1;
        w_lastNibble = (r_count == CW'(NIB - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_opA    <= '0;
            r_opB    <= '0;
            r_result <= '0;
            r_sum    <= '0;
            r_count  <= '0;
            r_carry  <= 1'b0;
            r_cout   <= 1'b0;
            r_done   <= 1'b0;
            r_doneId <= 1'b0;
            r_curId  <= 1'b0;
            r_lastId <= 1'b1;
            r_gnt    <= 2'b00;
        end else begin
            r_done <= 1'b0;
            r_gnt  <= 2'b00;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_opA    <= w_winner ? bus.a1   : bus.a0;
                        r_opB    <= w_winner ? bus.b1   : bus.b0;
                        r_carry  <= w_winner ? bus.cin1 : bus.cin0;
                        r_curId  <= w_winner;
                        r_lastId <= w_winner;
                        r_result <= '0;
                        r_count  <= '0;
                        r_gnt    <= w_winner ? 2'b10 : 2'b01;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_result <= w_resultNext;
                    r_carry  <= w_slice[4];
                    // Only the finished word is ever published on sum.
                    if (w_lastNibble) begin
                        r_sum    <= w_resultNext;
                        r_cout   <= w_slice[4];
                        r_doneId <= r_curId;
                        r_done   <= 1'b1;
                        r_count  <= '0;
                        r_state  <= IDLE;
                    end else begin
                        r_count <= r_count + CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt     = r_gnt;
    assign bus.busy    = (r_state == RUN);
    assign bus.sum     = r_sum;
    assign bus.cout    = r_cout;
    assign bus.done    = r_done;
    assign bus.done_id = r_doneId;
endmodule

// File: tb/tb_nibble_add_ctrl.sv
// Randomised and directed checks of nibble_add_ctrl against a whole-word
// arithmetic and round-robin model kept in the bench.
module tb_nibble_add_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk;
    logic rst;
    int   nCompared;
    int   nMismatched;

    nibble_add_ctrl_if #(.NIB(NIB)) bus ();

    nibble_add_ctrl #(.NIB(NIB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] refAdd(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearReqs();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
    endtask

    task automatic doReset();
        clearReqs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Issues one request from a single requester and observes the whole operation.
    task automatic doOp(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output logic [1:0] gntSeen, output int doneCycle, output int doneCount,
                        output bit earlySum, output logic [W-1:0] sumOut, output logic coutOut,
                        output logic idOut);
        logic [W-1:0] sumBefore;
        if (id) begin
            bus.a1 = a; bus.b1 = b; bus.cin1 = cin; bus.req1 = 1'b1;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.cin0 = cin; bus.req0 = 1'b1;
        end
        sumBefore = bus.sum;
        tick();
        gntSeen = bus.gnt;
        clearReqs();
        doneCycle = -1;
        doneCount = 0;
        earlySum  = 1'b0;
        sumOut    = '0;
        coutOut   = 1'b0;
        idOut     = 1'b0;
        for (int c = 1; c <= NIB + 1; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                doneCount++;
                if (doneCycle < 0) begin
                    doneCycle = c;
                    sumOut    = bus.sum;
                    coutOut   = bus.cout;
                    idOut     = bus.done_id;
                end
            end else if (doneCycle < 0 && bus.sum !== sumBefore) begin
                earlySum = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        rst = 1'b1;
        tick();
        nCompared++;
        if (bus.gnt !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b want 00", bus.gnt); end
        nCompared++;
        if (bus.busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
        nCompared++;
        if (bus.done !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_done: got %b want 0", bus.done); end
        nCompared++;
        if (bus.sum !== '0 || bus.cout !== 1'b0 || bus.done_id !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_result: got sum=%h cout=%b id=%b want 0/0/0", bus.sum, bus.cout, bus.done_id);
        end
        clearReqs();
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [W-1:0] tA   [4] = '{16'h1234, 16'h000F, 16'hFFFF, 16'hFFFF};
        logic [W-1:0] tB   [4] = '{16'h4321, 16'h0001, 16'h0001, 16'hFFFF};
        logic         tCin [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        bit           tId  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [W-1:0] tSum [4] = '{16'h5555, 16'h0010, 16'h0000, 16'hFFFF};
        logic         tCout[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [1:0]   gntSeen;
        int           doneCycle, doneCount;
        bit           earlySum;
        logic [W-1:0] sumOut;
        logic         coutOut, idOut;
        for (int i = 0; i < 4; i++) begin
            doOp(tId[i], tA[i], tB[i], tCin[i], gntSeen, doneCycle, doneCount, earlySum, sumOut, coutOut, idOut);
            nCompared++;
            if (gntSeen !== (tId[i] ? 2'b10 : 2'b01)) begin
                nMismatched++; $display("[TB] FAIL directed%0d_gnt: got %b want %b", i, gntSeen, tId[i] ? 2'b10 : 2'b01);
            end
            nCompared++;
            if (doneCycle != NIB || doneCount != 1) begin
                nMismatched++; $display("[TB] FAIL directed%0d_latency: got cycle %0d count %0d want %0d/1", i, doneCycle, doneCount, NIB);
            end
            nCompared++;
            if (earlySum !== 1'b0) begin
                nMismatched++; $display("[TB] FAIL directed%0d_early_sum: got 1 want 0", i);
            end
            nCompared++;
            if (sumOut !== tSum[i] || coutOut !== tCout[i]) begin
                nMismatched++; $display("[TB] FAIL directed%0d_sum: got %h/%b want %h/%b", i, sumOut, coutOut, tSum[i], tCout[i]);
            end
            nCompared++;
            if (idOut !== tId[i]) begin
                nMismatched++; $display("[TB] FAIL directed%0d_id: got %b want %b", i, idOut, tId[i]);
            end
            nCompared++;
            if (bus.sum !== tSum[i] || bus.cout !== tCout[i] || bus.done_id !== tId[i]) begin
                nMismatched++; $display("[TB] FAIL directed%0d_hold: got %h/%b/%b want %h/%b/%b", i, bus.sum, bus.cout, bus.done_id, tSum[i], tCout[i], tId[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [W:0] exp0, exp1, expRes;
        logic [1:0] expGnt;
        doReset();
        bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = 1'($urandom);
        bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.cin1 = 1'($urandom);
        exp0 = refAdd(bus.a0, bus.b0, bus.cin0);
        exp1 = refAdd(bus.a1, bus.b1, bus.cin1);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        // One operation every NIB+1 cycles, winners alternating from requester 0.
        for (int cyc = 0; cyc < 4 * (NIB + 1); cyc++) begin
            tick();
            expGnt = (cyc % (NIB + 1) != 0) ? 2'b00 : (((cyc / (NIB + 1)) % 2) != 0 ? 2'b10 : 2'b01);
            nCompared++;
            if (bus.gnt !== expGnt) begin
                nMismatched++; $display("[TB] FAIL rr_gnt@%0d: got %b want %b", cyc, bus.gnt, expGnt);
            end
            nCompared++;
            if (bus.busy !== (cyc % (NIB + 1) != NIB)) begin
                nMismatched++; $display("[TB] FAIL rr_busy@%0d: got %b want %b", cyc, bus.busy, cyc % (NIB + 1) != NIB);
            end
            nCompared++;
            if (bus.done !== (cyc % (NIB + 1) == NIB)) begin
                nMismatched++; $display("[TB] FAIL rr_done@%0d: got %b want %b", cyc, bus.done, cyc % (NIB + 1) == NIB);
            end
            if (cyc % (NIB + 1) == NIB) begin
                expRes = ((cyc / (NIB + 1)) % 2 != 0) ? exp1 : exp0;
                nCompared++;
                if (bus.done_id !== 1'((cyc / (NIB + 1)) % 2) || bus.sum !== expRes[W-1:0] || bus.cout !== expRes[W]) begin
                    nMismatched++;
                    $display("[TB] FAIL rr_result@%0d: got id=%b %h/%b want id=%0d %h/%b", cyc, bus.done_id, bus.sum, bus.cout, (cyc / (NIB + 1)) % 2, expRes[W-1:0], expRes[W]);
                end
            end
        end
        clearReqs();
        tick();
    endtask

    task automatic test_reset_mid_run();
        logic [1:0]   gntSeen;
        int           doneCycle, doneCount;
        bit           earlySum;
        logic [W-1:0] sumOut;
        logic         coutOut, idOut;
        logic [W:0]   expRes;
        doOp(1'b0, 16'h1111, 16'h2222, 1'b1, gntSeen, doneCycle, doneCount, earlySum, sumOut, coutOut, idOut);
        bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = 1'b1;
        bus.req0 = 1'b1;
        tick();
        nCompared++;
        if (bus.gnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL midrst_first_gnt: got %b want 01", bus.gnt); end
        clearReqs();
        tick();
        tick();
        // Reset lands on the edge that would process nibble 2, with both requests up.
        rst = 1'b1;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        bus.a0 = W'($urandom); bus.b0 = W'($urandom); bus.cin0 = 1'($urandom);
        bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.cin1 = 1'($urandom);
        expRes = refAdd(bus.a0, bus.b0, bus.cin0);
        tick();
        rst = 1'b0;
        nCompared++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.gnt !== 2'b00) begin
            nMismatched++; $display("[TB] FAIL midrst_status: got busy=%b done=%b gnt=%b want 0/0/00", bus.busy, bus.done, bus.gnt);
        end
        nCompared++;
        if (bus.sum !== '0 || bus.cout !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL midrst_result: got %h/%b want 0000/0", bus.sum, bus.cout);
        end
        tick();
        nCompared++;
        if (bus.gnt !== 2'b01) begin nMismatched++; $display("[TB] FAIL midrst_tie_gnt: got %b want 01", bus.gnt); end
        clearReqs();
        for (int c = 1; c <= NIB; c++) begin
            tick();
            nCompared++;
            if (bus.done !== (c == NIB)) begin
                nMismatched++; $display("[TB] FAIL midrst_done@%0d: got %b want %b", c, bus.done, c == NIB);
            end
        end
        nCompared++;
        if (bus.sum !== expRes[W-1:0] || bus.cout !== expRes[W] || bus.done_id !== 1'b0) begin
            nMismatched++; $display("[TB] FAIL midrst_after_sum: got %h/%b/%b want %h/%b/0", bus.sum, bus.cout, bus.done_id, expRes[W-1:0], expRes[W]);
        end
        tick();
    endtask

    task automatic test_ignore_during_run();
        logic [W:0] expRes;
        for (int n = 0; n < 4; n++) begin
            bus.a1 = W'($urandom); bus.b1 = W'($urandom); bus.cin1 = 1'($urandom);
            expRes = refAdd(bus.a1, bus.b1, bus.cin1);
            bus.req1 = 1'b1;
            tick();
            nCompared++;
            if (bus.gnt !== 2'b10) begin nMismatched++; $display("[TB] FAIL ignore%0d_gnt: got %b want 10", n, bus.gnt); end
            for (int c = 1; c <= NIB; c++) begin
                bus.req0 = 1'($urandom); bus.req1 = 1'($urandom);
                bus.a0 = W'($urandom); bus.b0 = W'($urandom);
                bus.a1 = W'($urandom); bus.b1 = W'($urandom);
                bus.cin0 = 1'($urandom); bus.cin1 = 1'($urandom);
                tick();
                nCompared++;
                if (bus.gnt !== 2'b00 || bus.done !== (c == NIB)) begin
                    nMismatched++; $display("[TB] FAIL ignore%0d_run@%0d: got gnt=%b done=%b want 00/%b", n, c, bus.gnt, bus.done, c == NIB);
                end
            end
            nCompared++;
            if (bus.sum !== expRes[W-1:0] || bus.cout !== expRes[W] || bus.done_id !== 1'b1) begin
                nMismatched++; $display("[TB] FAIL ignore%0d_sum: got %h/%b/%b want %h/%b/1", n, bus.sum, bus.cout, bus.done_id, expRes[W-1:0], expRes[W]);
            end
            clearReqs();
            tick();
        end
    endtask

    task automatic test_random();
        logic [1:0]   gntSeen;
        int           doneCycle, doneCount;
        bit           earlySum;
        logic [W-1:0] sumOut, a, b;
        logic         coutOut, idOut, cin;
        bit           id;
        logic [W:0]   expRes;
        for (int n = 0; n < 24; n++) begin
            id  = 1'($urandom);
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            expRes = refAdd(a, b, cin);
            doOp(id, a, b, cin, gntSeen, doneCycle, doneCount, earlySum, sumOut, coutOut, idOut);
            nCompared++;
            if (gntSeen !== (id ? 2'b10 : 2'b01) || doneCycle != NIB || doneCount != 1) begin
                nMismatched++; $display("[TB] FAIL random%0d_timing: got gnt=%b cycle=%0d count=%0d", n, gntSeen, doneCycle, doneCount);
            end
            nCompared++;
            if (sumOut !== expRes[W-1:0] || coutOut !== expRes[W] || idOut !== id || earlySum !== 1'b0) begin
                nMismatched++;
                $display("[TB] FAIL random%0d_result: got %h/%b id=%b early=%b want %h/%b id=%b", n, sumOut, coutOut, idOut, earlySum, expRes[W-1:0], expRes[W], id);
            end
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        rst = 1'b1;
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        bus.cin0 = 1'b0; bus.cin1 = 1'b0;
        tick();
        test_reset();
        test_directed();
        test_round_robin();
        test_reset_mid_run();
        test_ignore_during_run();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
